// File: rtl/traffic_light_xing.sv
// rtl/traffic_light_xing.sv - two-road intersection controller with pedestrian shortening and flash mode
module traffic_light_xing #(
  parameter int CNT_W     = 8,
  parameter int GREEN_T   = 60,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int MIN_GREEN = 10,
  parameter int FLASH_T   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pass_request,
  input  logic             flash_mode,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic [CNT_W-1:0] clock,
  output logic [2:0]       phase
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NS_G  = 3'd1;
  localparam logic [2:0] S_NS_Y  = 3'd2;
  localparam logic [2:0] S_AR1   = 3'd3;
  localparam logic [2:0] S_EW_G  = 3'd4;
  localparam logic [2:0] S_EW_Y  = 3'd5;
  localparam logic [2:0] S_AR2   = 3'd6;
  localparam logic [2:0] S_FLASH = 3'd7;

  localparam logic [CNT_W-1:0] T_GREEN = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] T_AR    = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] T_MIN   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] T_FL    = CNT_W'(FLASH_T);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] clock_q, clock_d;
  logic             tog_q, tog_d;
  logic [5:0]       lamps_q, lamps_d;
  logic             is_green;

  assign is_green = (state_q == S_NS_G) || (state_q == S_EW_G);

  // Priority: IDLE exit, flash, flash exit, phase end, pedestrian shortening, countdown.
  always_comb begin
    state_d = state_q;
    clock_d = clock_q;
    tog_d   = tog_q;
    if (state_q == S_IDLE) begin
      state_d = S_AR2;
      clock_d = T_AR;
      tog_d   = 1'b0;
    end else if (flash_mode) begin
      if (state_q != S_FLASH) begin
        state_d = S_FLASH;
        clock_d = T_FL;
        tog_d   = 1'b1;
      end else if (clock_q == ONE) begin
        clock_d = T_FL;
        tog_d   = ~tog_q;
      end else begin
        clock_d = clock_q - ONE;
      end
    end else if (state_q == S_FLASH) begin
      state_d = S_AR2;
      clock_d = T_AR;
      tog_d   = 1'b0;
    end else if (clock_q == ONE) begin
      case (state_q)
        S_NS_G:  begin state_d = S_NS_Y; clock_d = T_YEL;   end
        S_NS_Y:  begin state_d = S_AR1;  clock_d = T_AR;    end
        S_AR1:   begin state_d = S_EW_G; clock_d = T_GREEN; end
        S_EW_G:  begin state_d = S_EW_Y; clock_d = T_YEL;   end
        S_EW_Y:  begin state_d = S_AR2;  clock_d = T_AR;    end
        default: begin state_d = S_NS_G; clock_d = T_GREEN; end
      endcase
    end else if (pass_request && is_green && (clock_q > T_MIN)) begin
      clock_d = T_MIN;
    end else begin
      clock_d = clock_q - ONE;
    end
  end

  // Lamp order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}.
  always_comb begin
    lamps_d = 6'b000000;
    case (state_d)
      S_NS_G:       lamps_d = 6'b001100;
      S_NS_Y:       lamps_d = 6'b010100;
      S_AR1, S_AR2: lamps_d = 6'b100100;
      S_EW_G:       lamps_d = 6'b100001;
      S_EW_Y:       lamps_d = 6'b100010;
      S_FLASH:      lamps_d = {1'b0, tog_d, 1'b0, 1'b0, tog_d, 1'b0};
      default:      lamps_d = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      clock_q <= '0;
      tog_q   <= 1'b0;
      lamps_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      clock_q <= clock_d;
      tog_q   <= tog_d;
      lamps_q <= lamps_d;
    end
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamps_q;
  assign clock = clock_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_xing.sv
// tb/tb_traffic_light_xing.sv - scoreboard bench for traffic_light_xing
module tb_traffic_light_xing;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pass_request;
  logic       flash_mode;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [7:0] clock;
  logic [2:0] phase;

  traffic_light_xing dut (
    .clk(clk), .rst_n(rst_n), .pass_request(pass_request), .flash_mode(flash_mode),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .clock(clock), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic [7:0] ck;
    logic [5:0] lamps;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Edges since the last reset release; held at 0 while in reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [5:0] lamps_for(input int ph, input bit tog);
    case (ph)
      1:       return 6'b001100;
      2:       return 6'b010100;
      3, 6:    return 6'b100100;
      4:       return 6'b100001;
      5:       return 6'b100010;
      7:       return {1'b0, tog, 1'b0, 1'b0, tog, 1'b0};
      default: return 6'b000000;
    endcase
  endfunction

  task automatic push(input int c, input int ph, input int ck, input bit tog = 1'b0);
    exp_t x;
    x.cyc   = c;
    x.ph    = 3'(ph);
    x.ck    = 8'(ck);
    x.lamps = lamps_for(ph, tog);
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL missed_check: expectation for cycle %0d not sampled (now %0d)", e.cyc, cyc);
      end else if (phase !== e.ph || clock !== e.ck ||
                   {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} !== e.lamps) begin
        bad++;
        $display("FAIL cyc%0d: phase=%0d clock=%0d lamps=%b, required phase=%0d clock=%0d lamps=%b",
                 cyc, phase, clock, {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green},
                 e.ph, e.ck, e.lamps);
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b1;
    pass_request = 1'b0;
    flash_mode = 1'b0;
    #1 rst_n = 1'b0;
    push(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Power-up sequence and one full period
    push(1, 6, 2);   push(2, 6, 1);   push(3, 1, 60);  push(62, 1, 1);
    push(63, 2, 5);  push(68, 3, 2);  push(70, 4, 60); push(130, 5, 5);
    push(135, 6, 2); push(137, 1, 60);

    // Single-cycle pedestrian request at clock=40
    push(157, 1, 40); push(158, 1, 10); push(167, 1, 1); push(168, 2, 5);
    wait_cyc(157); pass_request = 1'b1;
    wait_cyc(158); pass_request = 1'b0;

    // Held request with clock already below MIN_GREEN, released on the AR2->NS_G edge
    push(227, 4, 8);  push(228, 4, 7);  push(234, 4, 1);  push(235, 5, 5);
    push(240, 6, 2);  push(242, 1, 60); push(243, 1, 59);
    wait_cyc(227); pass_request = 1'b1;
    wait_cyc(242); pass_request = 1'b0;

    // Flash and request together in NS_G
    push(272, 1, 30);   push(273, 7, 4, 1); push(276, 7, 1, 1); push(277, 7, 4, 0);
    push(281, 7, 4, 1); push(283, 7, 2, 1); push(284, 6, 2);    push(286, 1, 60);
    push(287, 1, 59);
    wait_cyc(272); flash_mode = 1'b1; pass_request = 1'b1;
    wait_cyc(273); pass_request = 1'b0;
    wait_cyc(283); flash_mode = 1'b0;

    // Flash entered from EW_G
    push(353, 4, 60);   push(360, 4, 53);   push(361, 7, 4, 1); push(365, 7, 4, 0);
    push(369, 7, 4, 1); push(370, 7, 3, 1); push(371, 6, 2);    push(373, 1, 60);
    wait_cyc(360); flash_mode = 1'b1;
    wait_cyc(370); flash_mode = 1'b0;

    // Asynchronous reset between edges during NS_Y
    push(433, 2, 5);
    wait_cyc(434);
    #2 rst_n = 1'b0;
    push(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push(1, 6, 2); push(3, 1, 60); push(63, 2, 5); push(70, 4, 60);

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL timeout: expectation for cycle %0d never checked", e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
